// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between a fetch (read-only) and a data (read/write)
// requester. Data side wins ties unless fetch has waited STARVE_MAX consecutive data grants.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              stall_if,
  output logic              stall_dm,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SERV_I = 2'd1,
    ST_SERV_D = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic [CNT_W-1:0]  w_starve_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic              r_if_done;
  logic              r_dm_done;

  logic w_if_elig;
  logic w_dm_elig;
  logic w_grant_i;
  logic w_grant_d;
  logic w_complete_i;
  logic w_complete_d;

  // A requester still holding req in its done cycle is not re-granted.
  assign w_if_elig = if_req & ~r_if_done;
  assign w_dm_elig = dm_req & ~r_dm_done;

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    w_complete_i = 1'b0;
    w_complete_d = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_if_elig && w_dm_elig) begin
          if (r_starve_cnt == CNT_MAX) w_grant_i = 1'b1;
          else                         w_grant_d = 1'b1;
        end else if (w_if_elig) begin
          w_grant_i = 1'b1;
        end else if (w_dm_elig) begin
          w_grant_d = 1'b1;
        end
        if (w_grant_i)      w_state_nxt = ST_SERV_I;
        else if (w_grant_d) w_state_nxt = ST_SERV_D;
      end
      ST_SERV_I: begin
        if (mem_ready) begin
          w_state_nxt  = ST_IDLE;
          w_complete_i = 1'b1;
        end
      end
      ST_SERV_D: begin
        if (mem_ready) begin
          w_state_nxt  = ST_IDLE;
          w_complete_d = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (w_grant_i) begin
      w_starve_nxt = '0;
    end else if (w_grant_d && if_req && (r_starve_cnt < CNT_MAX)) begin
      w_starve_nxt = r_starve_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  // Transaction registers only load on a grant, so inputs moving mid-transaction are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end else if (w_grant_i) begin
      r_addr  <= if_addr;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end else if (w_grant_d) begin
      r_addr  <= dm_addr;
      r_wdata <= dm_wdata;
      r_we    <= dm_we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_done  <= 1'b0;
      r_dm_done  <= 1'b0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      r_if_done <= w_complete_i;
      r_dm_done <= w_complete_d;
      if (w_complete_i)          r_if_rdata <= mem_rdata;
      if (w_complete_d && !r_we) r_dm_rdata <= mem_rdata;
    end
  end

  assign mem_req   = (r_state == ST_SERV_I) || (r_state == ST_SERV_D);
  assign mem_we    = (r_state == ST_SERV_D) && r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign if_done   = r_if_done;
  assign dm_done   = r_dm_done;
  assign stall_if  = if_req & ~r_if_done;
  assign stall_dm  = dm_req & ~r_dm_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: scenario tasks with cycle-exact checks plus a completion scoreboard.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic        z_if_req = 1'b0, z_dm_req = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_done, dm_done, stall_if, stall_dm, mem_req, mem_we;
  logic [31:0] z_if_rdata, z_dm_rdata, z_mem_addr, z_mem_wdata;
  logic        z_if_done, z_dm_done, z_stall_if, z_stall_dm, z_mem_req, z_mem_we;

  int total = 0;
  int bad = 0;
  int mem_wait = 0;
  int wcnt = 0;
  logic [31:0] last_dm = '0;

  typedef struct {
    bit          is_dm;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];
  exp_t e_if, e_dm;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done),
    .stall_if(stall_if), .stall_dm(stall_dm),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  // Second instance with fetch always winning ties; its memory never waits.
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .if_req(z_if_req), .if_addr(if_addr), .if_rdata(z_if_rdata), .if_done(z_if_done),
    .dm_req(z_dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(z_dm_rdata), .dm_done(z_dm_done),
    .stall_if(z_stall_if), .stall_dm(z_stall_dm),
    .mem_req(z_mem_req), .mem_we(z_mem_we), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
    .mem_ready(1'b1), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory model: mem_wait cycles of mem_ready=0, then one ready cycle with read data.
  always @(negedge clk) begin
    if (mem_req) begin
      if (wcnt >= mem_wait) begin
        mem_ready = 1'b1;
        mem_rdata = rd_val(mem_addr);
      end else begin
        mem_ready = 1'b0;
        wcnt++;
      end
    end else begin
      mem_ready = 1'b0;
      wcnt = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && if_done) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_if_unexpected: if_done with nothing expected, rdata=%h", if_rdata);
      end else begin
        e_if = exp_q.pop_front();
        if (e_if.is_dm || if_rdata !== e_if.data) begin
          bad++;
          $display("FAIL sb_if: got fetch done rdata=%h, required %s done data=%h",
                   if_rdata, e_if.is_dm ? "data" : "fetch", e_if.data);
        end
      end
    end
    if (rst_n && dm_done) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_dm_unexpected: dm_done with nothing expected, rdata=%h", dm_rdata);
      end else begin
        e_dm = exp_q.pop_front();
        if (!e_dm.is_dm || dm_rdata !== e_dm.data) begin
          bad++;
          $display("FAIL sb_dm: got data done rdata=%h, required %s done data=%h",
                   dm_rdata, e_dm.is_dm ? "data" : "fetch", e_dm.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input bit is_dm, input logic [31:0] d);
    exp_q.push_back('{is_dm: is_dm, data: d});
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    total++;
    if ({mem_req, mem_we, if_done, dm_done, stall_if, stall_dm} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got req/we/ifd/dmd/sif/sdm=%b, required 000000",
               {mem_req, mem_we, if_done, dm_done, stall_if, stall_dm});
    end
    total++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_data: got addr=%h wdata=%h if_rdata=%h dm_rdata=%h, required all 0",
               mem_addr, mem_wdata, if_rdata, dm_rdata);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (mem_req !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: got mem_req=%b, required 0", mem_req);
    end
  endtask

  task automatic test_fetch();
    if_req = 1'b1;
    if_addr = 32'h100;
    push_exp(1'b0, 32'h0050_0093);
    #1;
    total++;
    if (stall_if !== 1'b1) begin
      bad++;
      $display("FAIL fetch_stall_c0: got stall_if=%b, required 1", stall_if);
    end
    tick();
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 || stall_if !== 1'b1 || if_done !== 1'b0) begin
      bad++;
      $display("FAIL fetch_c1: got req=%b addr=%h we=%b stall=%b done=%b, required 1 00000100 0 1 0",
               mem_req, mem_addr, mem_we, stall_if, if_done);
    end
    tick();
    total++;
    if (if_done !== 1'b1 || if_rdata !== 32'h0050_0093 || stall_if !== 1'b0 || mem_req !== 1'b0) begin
      bad++;
      $display("FAIL fetch_c2: got done=%b rdata=%h stall=%b req=%b, required 1 00500093 0 0",
               if_done, if_rdata, stall_if, mem_req);
    end
    if_req = 1'b0;
    tick();
    total++;
    if (if_done !== 1'b0) begin
      bad++;
      $display("FAIL fetch_pulse: got if_done=%b in c3, required 0", if_done);
    end
  endtask

  task automatic test_priority();
    if_req = 1'b1; if_addr = 32'h104;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3000;
    push_exp(1'b1, rd_val(32'h3000));
    push_exp(1'b0, rd_val(32'h104));
    last_dm = rd_val(32'h3000);
    tick();
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h3000 || stall_if !== 1'b1) begin
      bad++;
      $display("FAIL prio_c1: got req=%b addr=%h stall_if=%b, required 1 00003000 1", mem_req, mem_addr, stall_if);
    end
    tick();
    total++;
    if (dm_done !== 1'b1 || mem_req !== 1'b0 || stall_dm !== 1'b0) begin
      bad++;
      $display("FAIL prio_c2: got dm_done=%b req=%b stall_dm=%b, required 1 0 0", dm_done, mem_req, stall_dm);
    end
    dm_req = 1'b0;
    tick();
    total++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h104) begin
      bad++;
      $display("FAIL prio_c3: got req=%b addr=%h, required 1 00000104", mem_req, mem_addr);
    end
    tick();
    total++;
    if (if_done !== 1'b1) begin
      bad++;
      $display("FAIL prio_c4: got if_done=%b, required 1", if_done);
    end
    if_req = 1'b0;
    tick();
  endtask

  // Fetch raised alongside data each round, withdrawn after losing; the 5th tie goes to fetch.
  task automatic test_starve();
    logic [31:0] da;
    for (int r = 0; r < 4; r++) begin
      da = 32'h5000 + 32'(r * 4);
      if_req = 1'b1; if_addr = 32'h200 + 32'(r * 4);
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = da;
      push_exp(1'b1, rd_val(da));
      last_dm = rd_val(da);
      tick();
      total++;
      if (mem_addr !== da || mem_req !== 1'b1) begin
        bad++;
        $display("FAIL starve_dgrant%0d: got req=%b addr=%h, required 1 %h", r, mem_req, mem_addr, da);
      end
      if_req = 1'b0;
      tick();
      dm_req = 1'b0;
      tick();
    end
    if_req = 1'b1; if_addr = 32'h210;
    dm_req = 1'b1; dm_addr = 32'h5010;
    push_exp(1'b0, rd_val(32'h210));
    push_exp(1'b1, rd_val(32'h5010));
    last_dm = rd_val(32'h5010);
    tick();
    total++;
    if (mem_addr !== 32'h210 || mem_req !== 1'b1) begin
      bad++;
      $display("FAIL starve_fetch_win: got req=%b addr=%h, required 1 00000210", mem_req, mem_addr);
    end
    tick();
    if_req = 1'b0;
    tick();
    total++;
    if (mem_addr !== 32'h5010 || mem_req !== 1'b1) begin
      bad++;
      $display("FAIL starve_after: got req=%b addr=%h, required 1 00005010", mem_req, mem_addr);
    end
    tick();
    dm_req = 1'b0;
    tick();
    // Counter cleared by the fetch grant, so data wins the next tie again.
    if_req = 1'b1; if_addr = 32'h214;
    dm_req = 1'b1; dm_addr = 32'h5014;
    push_exp(1'b1, rd_val(32'h5014));
    push_exp(1'b0, rd_val(32'h214));
    last_dm = rd_val(32'h5014);
    tick();
    total++;
    if (mem_addr !== 32'h5014) begin
      bad++;
      $display("FAIL starve_cleared: got addr=%h, required 00005014", mem_addr);
    end
    tick();
    dm_req = 1'b0;
    repeat (2) tick();
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_write_wait();
    mem_wait = 3;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'hDEAD_BEEF;
    push_exp(1'b1, last_dm);
    for (int c = 1; c <= 4; c++) begin
      tick();
      total++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h2000 ||
          mem_wdata !== 32'hDEAD_BEEF || dm_done !== 1'b0) begin
        bad++;
        $display("FAIL write_hold_c%0d: got req=%b we=%b addr=%h wdata=%h done=%b, required 1 1 00002000 deadbeef 0",
                 c, mem_req, mem_we, mem_addr, mem_wdata, dm_done);
      end
      if (c == 2) begin
        dm_addr = 32'h2F00; dm_wdata = 32'h1234_5678; dm_we = 1'b0;
      end
    end
    tick();
    total++;
    if (dm_done !== 1'b1 || dm_rdata !== last_dm || mem_req !== 1'b0 || mem_we !== 1'b0) begin
      bad++;
      $display("FAIL write_c5: got done=%b rdata=%h req=%b we=%b, required 1 %h 0 0",
               dm_done, dm_rdata, mem_req, mem_we, last_dm);
    end
    dm_req = 1'b0; dm_we = 1'b0; mem_wait = 0;
    tick();
  endtask

  task automatic test_fetch_first();
    rst_n = 1'b0;
    tick();
    last_dm = '0;
    rst_n = 1'b1;
    tick();
    if_req = 1'b1; z_if_req = 1'b1; if_addr = 32'h300;
    dm_req = 1'b1; z_dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h6000;
    push_exp(1'b1, rd_val(32'h6000));
    push_exp(1'b0, rd_val(32'h300));
    last_dm = rd_val(32'h6000);
    tick();
    total++;
    if (z_mem_req !== 1'b1 || z_mem_addr !== 32'h300) begin
      bad++;
      $display("FAIL sm0_fetch_first: got req=%b addr=%h, required 1 00000300", z_mem_req, z_mem_addr);
    end
    tick();
    total++;
    if (z_if_done !== 1'b1 || z_dm_done !== 1'b0) begin
      bad++;
      $display("FAIL sm0_if_done: got if_done=%b dm_done=%b, required 1 0", z_if_done, z_dm_done);
    end
    z_if_req = 1'b0;
    dm_req = 1'b0;
    tick();
    total++;
    if (z_mem_req !== 1'b1 || z_mem_addr !== 32'h6000) begin
      bad++;
      $display("FAIL sm0_data_next: got req=%b addr=%h, required 1 00006000", z_mem_req, z_mem_addr);
    end
    tick();
    total++;
    if (z_dm_done !== 1'b1) begin
      bad++;
      $display("FAIL sm0_dm_done: got dm_done=%b, required 1", z_dm_done);
    end
    z_dm_req = 1'b0;
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    mem_wait = 10;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h4000;
    repeat (2) tick();
    total++;
    if (mem_req !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_busy: got mem_req=%b, required 1", mem_req);
    end
    rst_n = 1'b0;
    dm_req = 1'b0;
    #1;
    total++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || dm_done !== 1'b0 ||
        dm_rdata !== 32'h0 || stall_dm !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_async: got req=%b we=%b addr=%h done=%b rdata=%h stall=%b, required all 0",
               mem_req, mem_we, mem_addr, dm_done, dm_rdata, stall_dm);
    end
    tick();
    mem_wait = 0;
    last_dm = '0;
    rst_n = 1'b1;
    tick();
    test_fetch();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_starve();
    test_write_wait();
    test_fetch_first();
    test_reset_mid();
    repeat (3) tick();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d completions still expected, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
